// File: rtl/mat_csc_gen_if.sv
// Stream bundle for mat_csc_gen: random-word input, entry output and column-pointer output.
// master = generator side, slave = environment side.
interface mat_csc_gen_if #(
    parameter int RAND_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8,
    parameter int PTR_W  = 12
);
    logic              rand_vld;
    logic              rand_rdy;
    logic [RAND_W-1:0] rand_row;
    logic [DATA_W-1:0] rand_re;
    logic [DATA_W-1:0] rand_im;

    logic              ent_vld;
    logic              ent_rdy;
    logic [IDX_W-1:0]  ent_row;
    logic [IDX_W-1:0]  ent_col;
    logic [DATA_W-1:0] ent_re;
    logic [DATA_W-1:0] ent_im;
    logic              ent_last_col;
    logic              ent_last;

    logic              colptr_vld;
    logic              colptr_rdy;
    logic [PTR_W-1:0]  colptr_val;

    modport master (
        input  rand_vld, rand_row, rand_re, rand_im, ent_rdy, colptr_rdy,
        output rand_rdy, ent_vld, ent_row, ent_col, ent_re, ent_im,
               ent_last_col, ent_last, colptr_vld, colptr_val
    );

    modport slave (
        output rand_vld, rand_row, rand_re, rand_im, ent_rdy, colptr_rdy,
        input  rand_rdy, ent_vld, ent_row, ent_col, ent_re, ent_im,
               ent_last_col, ent_last, colptr_vld, colptr_val
    );
endinterface

// File: rtl/mat_csc_gen.sv
// Sparse MAT_RANK x MAT_RANK complex matrix generator streaming CSC entries and column pointers.
// Optional completed-matrix counter output mat_cnt enabled by defining MAT_CSC_CNT_EN.
module mat_csc_gen #(
    parameter int SUBCAR_NUM   = 16,
    parameter int OFDM_SYM_NUM = 16,
    parameter int RAND_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LOG2_NNZ_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         cfg_log2nnz,
    mat_csc_gen_if.master      bus,
    output logic               busy,
    output logic               done
`ifdef MAT_CSC_CNT_EN
    ,
    output logic [15:0]        mat_cnt
`endif
);
    localparam int MAT_RANK  = SUBCAR_NUM * OFDM_SYM_NUM;
    localparam int LOG2_RANK = $clog2(MAT_RANK);
    localparam int IDX_W     = LOG2_RANK;
    localparam int PTR_W     = LOG2_RANK + LOG2_NNZ_MAX + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GEN = 2'd1, ST_FIN = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [2:0]        n_q, n_d;
    logic [IDX_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0]  slot_q, slot_d;
    logic              fin_ptr_q, fin_ptr_d;
    logic              ent_vld_q, ent_vld_d;
    logic [IDX_W-1:0]  ent_row_q, ent_row_d;
    logic [IDX_W-1:0]  ent_col_q, ent_col_d;
    logic [DATA_W-1:0] ent_re_q, ent_re_d;
    logic [DATA_W-1:0] ent_im_q, ent_im_d;
    logic              ent_last_col_q, ent_last_col_d;
    logic              ent_last_q, ent_last_d;
    logic              colptr_vld_q, colptr_vld_d;
    logic [PTR_W-1:0]  colptr_val_q, colptr_val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W:0]    nnz_s;
    logic [IDX_W-1:0]  slot_max_s;
    logic [IDX_W-1:0]  row_mask_s;
    logic [7:0]        seg_s;
    logic [IDX_W-1:0]  row_s;
    logic              last_col_s;
    logic              last_s;
    logic              ent_free_s;
    logic              ptr_free_s;
    logic              colptr_ok_s;
    logic              rand_rdy_s;
    logic              take_s;
    logic [2:0]        n_clamp_s;

    // Datapath helpers: slot wrap point, stratified row index and handshake qualifiers
    always_comb begin
        nnz_s       = (IDX_W+1)'(1) << n_q;
        slot_max_s  = IDX_W'(nnz_s - (IDX_W+1)'(1));
        row_mask_s  = {IDX_W{1'b1}} >> n_q;
        seg_s       = 8'(LOG2_RANK) - {5'd0, n_q};
        row_s       = (slot_q << seg_s) | (bus.rand_row[IDX_W-1:0] & row_mask_s);
        last_col_s  = (slot_q == slot_max_s);
        last_s      = last_col_s & (col_q == IDX_W'(MAT_RANK - 1));
        ent_free_s  = !ent_vld_q | bus.ent_rdy;
        ptr_free_s  = !colptr_vld_q | bus.colptr_rdy;
        // A column's first word also needs the pointer register, the others do not
        colptr_ok_s = (slot_q != {IDX_W{1'b0}}) | ptr_free_s;
        rand_rdy_s  = (state_q == ST_GEN) & ent_free_s & colptr_ok_s;
        take_s      = bus.rand_vld & rand_rdy_s;
        n_clamp_s   = (cfg_log2nnz > 3'(LOG2_NNZ_MAX)) ? 3'(LOG2_NNZ_MAX) : cfg_log2nnz;
    end

    // Next-state and output-register logic for the IDLE/GEN/FIN sequencer
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        col_d          = col_q;
        slot_d         = slot_q;
        fin_ptr_d      = fin_ptr_q;
        ent_vld_d      = ent_vld_q & !bus.ent_rdy;
        ent_row_d      = ent_row_q;
        ent_col_d      = ent_col_q;
        ent_re_d       = ent_re_q;
        ent_im_d       = ent_im_q;
        ent_last_col_d = ent_last_col_q;
        ent_last_d     = ent_last_q;
        colptr_vld_d   = colptr_vld_q & !bus.colptr_rdy;
        colptr_val_d   = colptr_val_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d       = n_clamp_s;
                    col_d     = {IDX_W{1'b0}};
                    slot_d    = {IDX_W{1'b0}};
                    fin_ptr_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ST_GEN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (take_s) begin
                    ent_vld_d      = 1'b1;
                    ent_row_d      = row_s;
                    ent_col_d      = col_q;
                    ent_re_d       = bus.rand_re;
                    ent_im_d       = bus.rand_im;
                    ent_last_col_d = last_col_s;
                    ent_last_d     = last_s;
                    if (slot_q == {IDX_W{1'b0}}) begin
                        colptr_vld_d = 1'b1;
                        colptr_val_d = PTR_W'(col_q) << n_q;
                    end else begin
                        colptr_val_d = colptr_val_q;
                    end
                    if (last_col_s) begin
                        slot_d = {IDX_W{1'b0}};
                        col_d  = col_q + IDX_W'(1);
                    end else begin
                        slot_d = slot_q + IDX_W'(1);
                    end
                    if (last_s) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_GEN;
                    end
                end else begin
                    state_d = ST_GEN;
                end
            end
            ST_FIN: begin
                if (!fin_ptr_q) begin
                    if (ptr_free_s) begin
                        colptr_vld_d = 1'b1;
                        colptr_val_d = PTR_W'(MAT_RANK) << n_q;
                        fin_ptr_d    = 1'b1;
                    end else begin
                        fin_ptr_d = 1'b0;
                    end
                end else if (ptr_free_s && ent_free_s) begin
                    // Final pointer and final entry have both left
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            n_q            <= 3'd0;
            col_q          <= {IDX_W{1'b0}};
            slot_q         <= {IDX_W{1'b0}};
            fin_ptr_q      <= 1'b0;
            ent_vld_q      <= 1'b0;
            ent_row_q      <= {IDX_W{1'b0}};
            ent_col_q      <= {IDX_W{1'b0}};
            ent_re_q       <= {DATA_W{1'b0}};
            ent_im_q       <= {DATA_W{1'b0}};
            ent_last_col_q <= 1'b0;
            ent_last_q     <= 1'b0;
            colptr_vld_q   <= 1'b0;
            colptr_val_q   <= {PTR_W{1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            col_q          <= col_d;
            slot_q         <= slot_d;
            fin_ptr_q      <= fin_ptr_d;
            ent_vld_q      <= ent_vld_d;
            ent_row_q      <= ent_row_d;
            ent_col_q      <= ent_col_d;
            ent_re_q       <= ent_re_d;
            ent_im_q       <= ent_im_d;
            ent_last_col_q <= ent_last_col_d;
            ent_last_q     <= ent_last_d;
            colptr_vld_q   <= colptr_vld_d;
            colptr_val_q   <= colptr_val_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef MAT_CSC_CNT_EN
    logic [15:0] mat_cnt_q, mat_cnt_d;

    // Completed-matrix counter, wraps naturally at 16 bits
    always_comb begin
        if (done_d) begin
            mat_cnt_d = mat_cnt_q + 16'd1;
        end else begin
            mat_cnt_d = mat_cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_cnt_q <= 16'd0;
        end else begin
            mat_cnt_q <= mat_cnt_d;
        end
    end

    assign mat_cnt = mat_cnt_q;
`endif

    assign bus.rand_rdy     = rand_rdy_s;
    assign bus.ent_vld      = ent_vld_q;
    assign bus.ent_row      = ent_row_q;
    assign bus.ent_col      = ent_col_q;
    assign bus.ent_re       = ent_re_q;
    assign bus.ent_im       = ent_im_q;
    assign bus.ent_last_col = ent_last_col_q;
    assign bus.ent_last     = ent_last_q;
    assign bus.colptr_vld   = colptr_vld_q;
    assign bus.colptr_val   = colptr_val_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_mat_csc_gen.sv
// Scoreboard bench for mat_csc_gen at MAT_RANK=16: the driver queues expected entries and
// pointers as it offers random words; a negedge monitor pops and compares every transfer.
module tb_mat_csc_gen;
    localparam int RANK = 16;
    localparam int IW   = 4;
    localparam int PW   = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] cfg;
    logic       busy;
    logic       done;
`ifdef MAT_CSC_CNT_EN
    logic [15:0] mat_cnt;
`endif

    mat_csc_gen_if #(.RAND_W(32), .DATA_W(32), .IDX_W(IW), .PTR_W(PW)) bus ();

    mat_csc_gen #(
        .SUBCAR_NUM(4), .OFDM_SYM_NUM(4), .RAND_W(32), .DATA_W(32), .LOG2_NNZ_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_log2nnz(cfg),
        .bus(bus), .busy(busy), .done(done)
`ifdef MAT_CSC_CNT_EN
        , .mat_cnt(mat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [31:0] re;
        logic [31:0] im;
        logic        lc;
        logic        l;
    } ent_t;

    ent_t       ent_q[$];
    logic [8:0] ptr_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  done_seen = 0;
    int  mats_since_rst = 0;
    int  last_ptr_cyc = -10;
    bit  bp_en = 1'b0;
    bit  chk_gap = 1'b0;
    bit  drv_slot0 = 1'b0;
    logic       pv_vld, pv_rdy;
    ent_t       pv_ent;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink-side ready generation
    initial begin
        bus.ent_rdy = 1'b1;
        bus.colptr_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ent_rdy    = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.colptr_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold stability, rand_rdy gating and done checks
    always @(negedge clk) begin
        ent_t got, exp;
        logic [8:0] pexp;
        if (!rst_n) begin
            pv_vld = 1'b0;
            pv_rdy = 1'b0;
        end else begin
            got = '{bus.ent_row, bus.ent_col, bus.ent_re, bus.ent_im, bus.ent_last_col, bus.ent_last};
            if (pv_vld && !pv_rdy) begin
                total++;
                if (!bus.ent_vld || got != pv_ent) begin
                    bad++;
                    $display("FAIL ent_hold: vld=%0b data=%h required held data=%h", bus.ent_vld, got, pv_ent);
                end
            end
            if (bus.ent_vld && bus.ent_rdy) begin
                total++;
                if (ent_q.size() == 0) begin
                    bad++;
                    $display("FAIL ent_unexpected: got %h with nothing expected", got);
                end else begin
                    exp = ent_q.pop_front();
                    if (got != exp) begin
                        bad++;
                        $display("FAIL ent: got row=%0d col=%0d re=%h im=%h lc=%0b l=%0b required row=%0d col=%0d re=%h im=%h lc=%0b l=%0b",
                                 got.row, got.col, got.re, got.im, got.lc, got.l,
                                 exp.row, exp.col, exp.re, exp.im, exp.lc, exp.l);
                    end
                end
            end
            if (bus.colptr_vld && bus.colptr_rdy) begin
                total++;
                last_ptr_cyc = cyc;
                if (ptr_q.size() == 0) begin
                    bad++;
                    $display("FAIL colptr_unexpected: got %0d", bus.colptr_val);
                end else begin
                    pexp = ptr_q.pop_front();
                    if (bus.colptr_val != pexp) begin
                        bad++;
                        $display("FAIL colptr: got %0d required %0d", bus.colptr_val, pexp);
                    end
                end
            end
            if (drv_slot0 && bus.rand_vld && bus.colptr_vld && !bus.colptr_rdy) begin
                total++;
                if (bus.rand_rdy) begin
                    bad++;
                    $display("FAIL rand_rdy_gate: got 1 required 0");
                end
            end
            if (done) begin
                total++;
                if (busy) begin
                    bad++;
                    $display("FAIL done_busy: busy=1 required 0");
                end
                if (chk_gap) begin
                    total++;
                    if (cyc - last_ptr_cyc != 1) begin
                        bad++;
                        $display("FAIL done_gap: got %0d cycles required 1", cyc - last_ptr_cyc);
                    end
                end
`ifdef MAT_CSC_CNT_EN
                total++;
                if (mat_cnt != 16'(mats_since_rst + 1)) begin
                    bad++;
                    $display("FAIL mat_cnt: got %0d required %0d", mat_cnt, mats_since_rst + 1);
                end
`endif
                mats_since_rst++;
                done_seen++;
            end
            pv_vld = bus.ent_vld;
            pv_rdy = bus.ent_rdy;
            pv_ent = got;
        end
    end

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Offer one matrix worth of words; called #1 after a posedge
    task automatic run_matrix(input int cfg_v, input bit rnd, input int abort_at, input int start_at);
        int n, nnz, tot, slot, col, ri, budget, d0;
        logic [31:0] seed;
        ent_t e;
        bit hs;
        n   = (cfg_v > 4) ? 4 : cfg_v;
        nnz = 1 << n;
        tot = RANK * nnz;
        cfg   = 3'(cfg_v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg   = 3'd0;
        for (int k = 0; k < tot; k++) begin
            if (k == abort_at) return;
            slot = k % nnz;
            col  = k / nnz;
            seed = rnd ? $urandom : 32'h3;
            ri   = (slot << (4 - n)) | (int'(seed[3:0]) & ((16 >> n) - 1));
            e.row = 4'(ri);
            e.col = 4'(col);
            e.re  = $urandom;
            e.im  = $urandom;
            e.lc  = (slot == nnz - 1);
            e.l   = e.lc && (col == RANK - 1);
            ent_q.push_back(e);
            if (slot == 0) ptr_q.push_back(9'(col << n));
            if (bp_en && ($urandom_range(0, 1) == 1)) begin
                bus.rand_vld = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.rand_vld = 1'b1;
            bus.rand_row = seed;
            bus.rand_re  = e.re;
            bus.rand_im  = e.im;
            drv_slot0    = (slot == 0);
            if (k == start_at) begin
                start = 1'b1;
                cfg   = 3'd4;
            end
            budget = 0;
            hs = 1'b0;
            while (!hs && budget < 500) begin
                @(negedge clk);
                hs = bus.rand_rdy;
                @(posedge clk);
                #1;
                start = 1'b0;
                budget++;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("FAIL rand_timeout: word %0d not accepted", k);
                summary_and_finish();
            end
        end
        bus.rand_vld = 1'b0;
        drv_slot0 = 1'b0;
        ptr_q.push_back(9'(RANK << n));
        d0 = done_seen;
        budget = 0;
        while (done_seen == d0 && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (done_seen == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", budget);
            summary_and_finish();
        end
    endtask

    initial begin
        int d_before;
        rst_n = 1'b0;
        start = 1'b0;
        cfg = 3'd0;
        bus.rand_vld = 1'b0;
        bus.rand_row = 32'd0;
        bus.rand_re = 32'd0;
        bus.rand_im = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.ent_vld || bus.colptr_vld || bus.rand_rdy || busy || done || bus.colptr_val != 9'd0) begin
            bad++;
            $display("FAIL reset_state: ent_vld=%0b colptr_vld=%0b rand_rdy=%0b busy=%0b done=%0b required all 0",
                     bus.ent_vld, bus.colptr_vld, bus.rand_rdy, busy, done);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk_gap = 1'b1;
        run_matrix(2, 1'b0, -1, -1);
        chk_gap = 1'b0;
        run_matrix(7, 1'b1, -1, -1);

        bp_en = 1'b1;
        run_matrix(3, 1'b1, -1, -1);
        run_matrix(1, 1'b1, -1, -1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        d_before = done_seen;
        run_matrix(2, 1'b1, -1, 10);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (busy || done_seen != d_before + 1) begin
            bad++;
            $display("FAIL start_ignored: busy=%0b matrices=%0d required busy=0 matrices=%0d",
                     busy, done_seen - d_before, 1);
        end

        run_matrix(2, 1'b1, 20, -1);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.ent_vld || bus.colptr_vld || bus.rand_rdy || busy || done ||
            bus.ent_row != 4'd0 || bus.colptr_val != 9'd0) begin
            bad++;
            $display("FAIL reset_abort: ent_vld=%0b colptr_vld=%0b rand_rdy=%0b busy=%0b required all 0",
                     bus.ent_vld, bus.colptr_vld, bus.rand_rdy, busy);
        end
        bus.rand_vld = 1'b0;
        drv_slot0 = 1'b0;
        ent_q.delete();
        ptr_q.delete();
        mats_since_rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_matrix(0, 1'b1, -1, -1);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (ent_q.size() != 0 || ptr_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries %0d pointers outstanding required 0 0", ent_q.size(), ptr_q.size());
        end
        summary_and_finish();
    end
endmodule
